// File: rtl/johnson_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : johnson_seq_checker
// Purpose  : Receive-side checker for a Johnson (twisted-ring) counter stream.
//            Each valid sample is decoded to a ring index and a one-hot
//            vector, checked for code legality and ring order, and fed to a
//            hunt/verify/lock state machine with a saturating error counter.
// Ports    : clk        - clock, rising edge
//            rstb       - synchronous active-high reset
//            in_valid   - st_in is sampled this cycle
//            st_in      - N-bit Johnson state word
//            clr_err    - synchronous clear of err_cnt
//            dec_idx    - decoded index of the last legal sample
//            dec_onehot - one-hot of dec_idx, zero for an illegal code
//            code_ok    - last valid sample was a legal code
//            seq_ok     - last valid sample was the ring successor
//            locked     - state machine is in LOCKED
//            err_pulse  - one-cycle pulse per error event
//            err_cnt    - saturating error count
// Revision : 1.0 - initial release
// ============================================================================
module johnson_seq_checker #(
    parameter int N        = 5,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   in_valid,
    input  logic [N-1:0]           st_in,
    input  logic                   clr_err,
    output logic [$clog2(2*N)-1:0] dec_idx,
    output logic [2*N-1:0]         dec_onehot,
    output logic                   code_ok,
    output logic                   seq_ok,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int c_RING_LEN = 2 * N;
    localparam int c_IDX_W    = $clog2(2 * N);
    localparam int c_RUN_W    = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Legal code for ring index k: the first N+1 indices fill ones from the
    // bottom, the remaining N-1 clear ones from the bottom of all-ones.
    function automatic logic [N-1:0] ring_code(input int k);
        logic [N-1:0] code;
        code = '0;
        for (int b = 0; b < N; b++) begin
            if (k <= N) begin
                code[b] = (b < k);
            end else begin
                code[b] = (b >= (k - N));
            end
        end
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Input sample stage. The whole sample, including its clr_err, is
    // captured together so a clear that arrives with an erroring sample
    // is seen as coincident with that error.
    // ------------------------------------------------------------------
    logic           smp_valid_q;
    logic [N-1:0]   smp_st_q;
    logic           smp_clr_q;

    always_ff @(posedge clk) begin
        if (rstb) begin
            smp_valid_q <= 1'b0;
            smp_st_q    <= '0;
            smp_clr_q   <= 1'b0;
        end else begin
            smp_valid_q <= in_valid;
            smp_st_q    <= st_in;
            smp_clr_q   <= clr_err;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the captured sample.
    // ------------------------------------------------------------------
    logic               w_legal;
    logic [c_IDX_W-1:0] w_idx;
    logic [2*N-1:0]     w_onehot;

    always_comb begin
        w_legal  = 1'b0;
        w_idx    = '0;
        w_onehot = '0;
        for (int k = 0; k < c_RING_LEN; k++) begin
            if (smp_st_q == ring_code(k)) begin
                w_legal     = 1'b1;
                w_idx       = c_IDX_W'(k);
                w_onehot[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs.
    // ------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [c_RUN_W-1:0] run_q,        run_d;
    logic [c_IDX_W-1:0] ref_idx_q,    ref_idx_d;
    logic [c_IDX_W-1:0] dec_idx_q,    dec_idx_d;
    logic [2*N-1:0]     dec_onehot_q, dec_onehot_d;
    logic               code_ok_q,    code_ok_d;
    logic               seq_ok_q,     seq_ok_d;
    logic               locked_q,     locked_d;
    logic               err_pulse_q,  err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;

    logic [c_IDX_W-1:0] w_succ_idx;
    logic               w_is_succ;

    // Ring successor of the stored index, wrapping 2N-1 -> 0.
    assign w_succ_idx = (ref_idx_q == c_IDX_W'(c_RING_LEN - 1)) ? '0
                                                                 : ref_idx_q + 1'b1;
    assign w_is_succ  = w_legal && (w_idx == w_succ_idx);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        ref_idx_d    = ref_idx_q;
        dec_idx_d    = dec_idx_q;
        dec_onehot_d = dec_onehot_q;
        code_ok_d    = code_ok_q;
        seq_ok_d     = seq_ok_q;
        err_pulse_d  = 1'b0;

        if (smp_valid_q) begin
            code_ok_d    = w_legal;
            dec_onehot_d = w_onehot;
            // In HUNT there is no trusted reference index, so no sample
            // there can count as a successor.
            seq_ok_d     = w_is_succ && (state_q != ST_HUNT);
            if (w_legal) begin
                dec_idx_d = w_idx;
            end

            unique case (state_q)
                ST_HUNT: begin
                    if (w_legal) begin
                        ref_idx_d = w_idx;
                        run_d     = '0;
                        state_d   = ST_VERIFY;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (!w_legal) begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else if (w_is_succ) begin
                        ref_idx_d = w_idx;
                        run_d     = run_q + 1'b1;
                        if (run_q == c_RUN_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        // A legal jump restarts verification from the new
                        // position without counting as an error.
                        ref_idx_d = w_idx;
                        run_d     = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_legal) begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else if (w_is_succ) begin
                        ref_idx_d = w_idx;
                    end else begin
                        err_pulse_d = 1'b1;
                        ref_idx_d   = w_idx;
                        run_d       = '0;
                        state_d     = ST_VERIFY;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // The clear acts whether or not the sample was valid; an error in
        // the same update leaves a count of one.
        err_cnt_d = err_cnt_q;
        if (smp_clr_q) begin
            err_cnt_d = err_pulse_d ? ERR_W'(1) : '0;
        end else if (err_pulse_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q      <= ST_HUNT;
            run_q        <= '0;
            ref_idx_q    <= '0;
            dec_idx_q    <= '0;
            dec_onehot_q <= '0;
            code_ok_q    <= 1'b0;
            seq_ok_q     <= 1'b0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            ref_idx_q    <= ref_idx_d;
            dec_idx_q    <= dec_idx_d;
            dec_onehot_q <= dec_onehot_d;
            code_ok_q    <= code_ok_d;
            seq_ok_q     <= seq_ok_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dec_idx    = dec_idx_q;
    assign dec_onehot = dec_onehot_q;
    assign code_ok    = code_ok_q;
    assign seq_ok     = seq_ok_q;
    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_seq_checker
// Purpose  : Self-checking bench for johnson_seq_checker. Two instances share
//            the stimulus: one at the default error width and one with a
//            2-bit error counter to reach saturation quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_seq_checker;

    localparam int N        = 5;
    localparam int LOCK_CNT = 4;
    localparam int RING     = 2 * N;
    localparam int IW       = $clog2(2 * N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstb;
    logic         in_valid;
    logic [N-1:0] st_in;
    logic         clr_err;

    logic [IW-1:0]  a_dec_idx,    b_dec_idx;
    logic [RING-1:0] a_dec_onehot, b_dec_onehot;
    logic a_code_ok, a_seq_ok, a_locked, a_err_pulse;
    logic b_code_ok, b_seq_ok, b_locked, b_err_pulse;
    logic [7:0] a_err_cnt;
    logic [1:0] b_err_cnt;

    johnson_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut_a (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .st_in(st_in), .clr_err(clr_err),
        .dec_idx(a_dec_idx), .dec_onehot(a_dec_onehot), .code_ok(a_code_ok),
        .seq_ok(a_seq_ok), .locked(a_locked), .err_pulse(a_err_pulse), .err_cnt(a_err_cnt)
    );

    johnson_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_b (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .st_in(st_in), .clr_err(clr_err),
        .dec_idx(b_dec_idx), .dec_onehot(b_dec_onehot), .code_ok(b_code_ok),
        .seq_ok(b_seq_ok), .locked(b_locked), .err_pulse(b_err_pulse), .err_cnt(b_err_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Ring table built by running the twisted-ring step from all-zero.
    int           code2idx[int];
    logic [N-1:0] idx2code[RING];

    // Reference model: modes 0=hunt, 1=verify, 2=locked.
    typedef struct {
        int idx;
        bit code_ok;
        bit seq_ok;
        bit locked;
        bit pulse;
        int cnt8;
        int cnt2;
    } exp_t;

    int   m_mode, m_ref, m_run;
    exp_t m_out, cur, pend;

    task automatic model_reset();
        m_mode = 0; m_ref = 0; m_run = 0;
        m_out = '{default: 0};
    endtask

    task automatic model_sample(input bit v, input logic [N-1:0] st, input bit c);
        bit legal, succ, err;
        int k;
        err = 0;
        k   = 0;
        m_out.pulse = 0;
        if (v) begin
            legal = code2idx.exists(int'(st));
            if (legal) k = code2idx[int'(st)];
            succ = legal && (m_mode != 0) && (k == (m_ref + 1) % RING);
            m_out.code_ok = legal;
            m_out.seq_ok  = succ;
            if (legal) m_out.idx = k;
            if (!legal) begin
                err = 1; m_mode = 0;
            end else if (m_mode == 0) begin
                m_ref = k; m_run = 0; m_mode = 1;
            end else if (succ) begin
                m_ref = k;
                if (m_mode == 1) begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_mode = 2;
                end
            end else begin
                if (m_mode == 2) err = 1;
                m_ref = k; m_run = 0; m_mode = 1;
            end
            m_out.locked = (m_mode == 2);
            m_out.pulse  = err;
        end
        if (c) begin
            m_out.cnt8 = err ? 1 : 0;
            m_out.cnt2 = err ? 1 : 0;
        end else if (err) begin
            if (m_out.cnt8 < 255) m_out.cnt8++;
            if (m_out.cnt2 < 3)   m_out.cnt2++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] oh;
        oh = cur.code_ok ? (32'd1 << cur.idx) : 32'd0;
        check_val("a_idx",    32'(a_dec_idx),    32'(cur.idx));
        check_val("a_onehot", 32'(a_dec_onehot), oh);
        check_val("a_code_ok", 32'(a_code_ok),   32'(cur.code_ok));
        check_val("a_seq_ok", 32'(a_seq_ok),     32'(cur.seq_ok));
        check_val("a_locked", 32'(a_locked),     32'(cur.locked));
        check_val("a_pulse",  32'(a_err_pulse),  32'(cur.pulse));
        check_val("a_cnt",    32'(a_err_cnt),    32'(cur.cnt8));
        check_val("b_idx",    32'(b_dec_idx),    32'(cur.idx));
        check_val("b_onehot", 32'(b_dec_onehot), oh);
        check_val("b_flags",  32'({b_code_ok, b_seq_ok, b_locked, b_err_pulse}),
                  32'({cur.code_ok, cur.seq_ok, cur.locked, cur.pulse}));
        check_val("b_cnt",    32'(b_err_cnt),    32'(cur.cnt2));
    endtask

    // One clock: drive inputs, let the edge take them, check outputs #1 later.
    task automatic step(input bit r, input bit v, input logic [N-1:0] st, input bit c);
        rstb = r; in_valid = v; st_in = st; clr_err = c;
        @(posedge clk);
        if (r) begin
            model_reset();
            cur  = m_out;
            pend = m_out;
        end else begin
            cur = pend;
            model_sample(v, st, c);
            pend = m_out;
        end
        #1;
        compare_all();
    endtask

    task automatic feed(input int k);
        step(1'b0, 1'b1, idx2code[k % RING], 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] s;
        logic [N-1:0] bad_code;
        int last_k, r;
        bit c;

        s = '0;
        for (int k = 0; k < RING; k++) begin
            code2idx[int'(s)] = k;
            idx2code[k]       = s;
            s = {s[N-2:0], ~s[N-1]};
        end
        bad_code = 5'b01010;

        rstb = 1'b1; in_valid = 1'b0; st_in = '0; clr_err = 1'b0;
        model_reset(); cur = m_out; pend = m_out;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, idx2code[3], 1'b1);
        check_val("reset_locked", 32'(a_locked), 32'd0);
        check_val("reset_cnt",    32'(a_err_cnt), 32'd0);

        // Lock latency: 4 samples not enough, 5th locks.
        for (int k = 0; k < 4; k++) feed(k);
        idle();
        check_val("lock_after4", 32'(a_locked), 32'd0);
        feed(4);
        idle();
        check_val("lock_after5", 32'(a_locked), 32'd1);

        // Walk the ring through the wrap, ending locked at idx 3.
        for (int k = 5; k < RING + 4; k++) feed(k);
        // Jump 3 -> 7, then relock via 8, 9, 0, 1.
        feed(7);
        for (int k = 8; k < 12; k++) feed(k);
        idle();
        check_val("relock_idx1", 32'(a_dec_idx), 32'd1);
        check_val("relock_lock", 32'(a_locked),  32'd1);

        // Illegal code while locked, then relock.
        step(1'b0, 1'b1, bad_code, 1'b0);
        for (int k = 2; k < 7; k++) feed(k);
        // Stall: idle three cycles, then repeat the last code.
        idle(); idle(); idle();
        feed(6);
        for (int k = 7; k < 12; k++) feed(k);

        // Saturate the 2-bit counter, then clear coincident with an error.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, bad_code, 1'b0);
        idle();
        check_val("sat_cnt2", 32'(b_err_cnt), 32'd3);
        step(1'b0, 1'b1, bad_code, 1'b1);
        idle();
        check_val("clr_with_err", 32'(b_err_cnt), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle();

        // Mid-stream reset after 16 locked cycles.
        for (int k = 0; k < 21; k++) feed(k);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, idx2code[2], 1'b0);
        for (int k = 3; k < 8; k++) feed(k);
        idle();
        check_val("post_rst_lock", 32'(a_locked), 32'd1);

        // Randomized traffic.
        last_k = 7;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            c = ($urandom_range(0, 24) == 0);
            if (r < 60) begin
                last_k = (last_k + 1) % RING;
                step(1'b0, 1'b1, idx2code[last_k], c);
            end else if (r < 70) begin
                step(1'b0, 1'b0, N'($urandom), c);
            end else if (r < 78) begin
                last_k = int'($urandom_range(0, RING - 1));
                step(1'b0, 1'b1, idx2code[last_k], c);
            end else if (r < 87) begin
                s = N'($urandom);
                if (code2idx.exists(int'(s))) last_k = code2idx[int'(s)];
                step(1'b0, 1'b1, s, c);
            end else if (r < 97) begin
                step(1'b0, 1'b1, idx2code[last_k], c);
            end else begin
                step(1'b1, 1'b1, idx2code[last_k], c);
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/johnson_seq_checker.md
# johnson_seq_checker

Receive-side checker for a Johnson (twisted-ring) counter stream. Each valid cycle it samples an N-bit Johnson state word, decodes it to a 2N-state index and a one-hot vector, checks code legality and ring-sequence order, and runs a hunt/verify/lock state machine with a saturating error counter. It sits downstream of the Johnson counter and provides a self-check on its `st_count` output in system and on the bench.

## Interface
- `N`, 5: number of Johnson stages; ring length is 2N; N ≥ 2.
- `LOCK_CNT`, 4: consecutive correct transitions needed to reach lock; ≥ 1.
- `ERR_W`, 8: error counter width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstb`  in  1  reset. One clock; reset is synchronous and active-high.
- `in_valid`  in  1  `st_in` is sampled on this cycle.
- `st_in`  in  N  Johnson state word.
- `clr_err`  in  1  synchronous clear of `err_cnt`.
- `dec_idx`  out  clog2(2N)  decoded index of the last valid sample (4 bits at N=5).
- `dec_onehot`  out  2N  one-hot of `dec_idx`; all zero when the code is illegal.
- `code_ok`  out  1  last valid sample was a legal Johnson code.
- `seq_ok`  out  1  last valid sample was the exact ring successor of the previous legal sample.
- `locked`  out  1  state machine is in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per error event.
- `err_cnt`  out  ERR_W  saturating error count.

## Operation
- Ring order: next = {st[N-2:0], ~st[N-1]}. Legal codes and indices:
  - idx k for 0 ≤ k ≤ N is (2^k − 1).
  - idx N+j for 1 ≤ j ≤ N−1 is all-ones with the low j bits cleared.
  - At N=5: 00000=0, 00001=1, 00111=3, 11111=5, 11110=6, 10000=9.
- Any other pattern is illegal. An illegal sample gives `code_ok`=0 and `dec_onehot`=0, and `dec_idx` holds its previous value.
- Successor test: new idx == (stored idx + 1) mod 2N. The index wraps from 2N−1 to 0. A repeated code (stall) is a sequence error.
- States, evaluated only on cycles with `in_valid`=1:
  - HUNT:
    - Legal sample: store idx, run=0, go to VERIFY.
    - Illegal sample: stay in HUNT.
  - VERIFY:
    - Legal successor: run+1. When run reaches LOCK_CNT, go to LOCKED.
    - Legal non-successor: store idx, run=0, stay in VERIFY.
    - Illegal sample: go to HUNT.
  - LOCKED:
    - Legal successor: stay in LOCKED.
    - Legal non-successor: error event, store idx, run=0, go to VERIFY.
    - Illegal sample: error event, go to HUNT.
- An illegal sample in HUNT or VERIFY is also an error event.
- Error event: `err_pulse`=1 for one cycle, and `err_cnt` increments, saturating at 2^ERR_W − 1.
- `clr_err` together with an error event sets `err_cnt` to 1. `clr_err` alone sets it to 0.
- When `in_valid`=0, all state and outputs hold, except `err_pulse`, which goes to 0. There is no timeout.

## Timing
- All outputs are registered, with 1-cycle latency. A sample taken at edge t is reflected in the outputs right after edge t+1.
- Lock latency with gap-free valid samples:
  - The first legal sample enters VERIFY.
  - `locked` rises with the update from sample LOCK_CNT+1, i.e. after the 5th consecutive correct sample at the default.
- `locked` falls in the same update that reports the error.
- Reset values: state HUNT, run=0, `dec_idx`=0, `dec_onehot`=0, `code_ok`=0, `seq_ok`=0, `locked`=0, `err_pulse`=0, `err_cnt`=0.
- Reset overrides `in_valid` and `clr_err`.
- Reset mid-stream returns the block to HUNT. The first post-reset sample is never compared against a pre-reset index.

## Test plan
- Reset, then feed the legal ring 00000, 00001, 00011, 00111, 01111, 11111, … with `in_valid`=1.
  - `locked`=1 after the 00111→01111 sample, i.e. after 5 samples.
  - `dec_idx` tracks 0..9 and wraps 9→0.
  - `err_cnt` stays 0.
- Locked, then inject the illegal code 01010.
  - `err_pulse`=1 for one cycle, `err_cnt`=1, `code_ok`=0, `dec_onehot`=0, `locked`=0, state HUNT.
  - Re-lock occurs 5 legal samples later.
- Locked at idx 3, then present idx 7 (11100).
  - `seq_ok`=0, `err_cnt`+1, state VERIFY.
  - Following with 8, 9, 0, 1 relocks on idx 1.
- Locked with stalls: drop `in_valid` for 3 cycles, then repeat the last code.
  - No change while idle.
  - The repeated code produces a sequence error.
- Force errors past saturation with ERR_W=2.
  - `err_cnt` sticks at 3.
  - `clr_err` coincident with an error gives `err_cnt`=1.
- Mid-stream `rstb` pulse while locked (e.g. `rstb` high 5 cycles after 16 locked cycles).
  - All outputs take their reset values.
  - The block relocks 5 samples after release with `err_cnt`=0.
